// File: rtl/trig_fl_pkg.sv
// Shared widths, quadrant type and the quarter-wave unfold helper for the trig
// expansion front/back end.
package trig_fl_pkg;

    localparam int IN_W  = 16;
    localparam int LUT_W = 16;
    localparam int IDX_W = 6;
    localparam int PH_W  = 7;
    localparam int OUT_W = 17;

    localparam logic [LUT_W-1:0] Q15_ONE = 16'h8000;

    typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_e;

    typedef struct packed {
        logic signed [OUT_W-1:0] sin_v;
        logic signed [OUT_W-1:0] cos_v;
    } sc_t;

    // Maps first-quadrant sin/cos (unsigned Q1.15) back to the full circle.
    // Negation happens in OUT_W, so -1.0 becomes 17'h18000 and -0 stays 0.
    function automatic sc_t unfold(input quad_e q,
                                   input logic [LUT_W-1:0] s,
                                   input logic [LUT_W-1:0] c);
        logic signed [OUT_W-1:0] sp;
        logic signed [OUT_W-1:0] cp;
        sc_t r;
        sp = {1'b0, s};
        cp = {1'b0, c};
        r  = '0;
        case (q)
            Q0: begin r.sin_v = sp;  r.cos_v = cp;  end
            Q1: begin r.sin_v = cp;  r.cos_v = -sp; end
            Q2: begin r.sin_v = -sp; r.cos_v = -cp; end
            Q3: begin r.sin_v = -cp; r.cos_v = sp;  end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/trig_expansion_fold_if.sv
// Sample-in / expansion-out stream bundle of the trig expansion fold block.
// Both directions use valid/ready: a transfer happens on a rising clk edge
// where valid and ready are both 1; the source holds valid and data stable
// until that edge, and ready may depend combinationally on the sink's state.
interface trig_expansion_fold_if;

    logic                                  in_valid;
    logic                                  in_ready;
    logic        [trig_fl_pkg::IN_W-1:0]   x_in;
    logic                                  out_valid;
    logic                                  out_ready;
    logic signed [trig_fl_pkg::OUT_W-1:0]  sin_k1;
    logic signed [trig_fl_pkg::OUT_W-1:0]  sin_k2;
    logic signed [trig_fl_pkg::OUT_W-1:0]  sin_k3;
    logic signed [trig_fl_pkg::OUT_W-1:0]  cos_k1;
    logic signed [trig_fl_pkg::OUT_W-1:0]  cos_k2;
    logic signed [trig_fl_pkg::OUT_W-1:0]  cos_k3;

    modport slave (
        input  in_valid, x_in, out_ready,
        output in_ready, out_valid,
        output sin_k1, sin_k2, sin_k3, cos_k1, cos_k2, cos_k3
    );

    modport master (
        output in_valid, x_in, out_ready,
        input  in_ready, out_valid,
        input  sin_k1, sin_k2, sin_k3, cos_k1, cos_k2, cos_k3
    );

endinterface

// File: rtl/phase_fold.sv
// Forms the rounded phase of harmonic K of a Q1.15 sample in pi/64 steps and
// splits it into quadrant and first-quadrant offset.
module phase_fold
    import trig_fl_pkg::*;
#(
    parameter int K = 1
) (
    input  logic [IN_W-1:0] x,
    output quad_e           q,
    output logic [4:0]      o
);

    logic signed [17:0]     prod;
    logic signed [17:0]     sum;
    logic        [PH_W-1:0] ph;

    // |K*x| <= 98304 fits in 18 signed bits; +256 rounds to the nearest pi/64.
    assign prod = $signed({{2{x[IN_W-1]}}, x}) * $signed(18'(K));
    assign sum  = prod + 18'sd256;
    assign ph   = PH_W'(sum >>> 9);

    assign q = quad_e'(ph[6:5]);
    assign o = ph[4:0];

endmodule

// File: rtl/trig_expansion_fold.sv
// Two-stage pipeline around a combinational quarter-wave sin/cos LUT: stage 0
// folds the phases of x, 2x, 3x; stage 1 unfolds the LUT returns to full range.
module trig_expansion_fold
    import trig_fl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    trig_expansion_fold_if.slave    bus,
    output logic [IDX_W-1:0]        lut_idx1,
    output logic [IDX_W-1:0]        lut_idx2,
    output logic [IDX_W-1:0]        lut_idx3,
    input  logic [LUT_W-1:0]        lut_sin1,
    input  logic [LUT_W-1:0]        lut_sin2,
    input  logic [LUT_W-1:0]        lut_sin3,
    input  logic [LUT_W-1:0]        lut_cos1,
    input  logic [LUT_W-1:0]        lut_cos2,
    input  logic [LUT_W-1:0]        lut_cos3
);

    localparam int NH = 3;

    logic             adv;
    quad_e            q_c [NH];
    logic [4:0]       o_c [NH];

    logic             s0_valid;
    quad_e            q_r [NH];
    logic [4:0]       o_r [NH];

    logic             out_valid_r;
    sc_t              sc_r [NH];

    logic [LUT_W-1:0] s_in [NH];
    logic [LUT_W-1:0] c_in [NH];

    // The whole pipe moves together; it only freezes when the output is blocked.
    assign adv          = !out_valid_r || bus.out_ready;
    assign bus.in_ready = adv;

    for (genvar g = 0; g < NH; g++) begin : g_fold
        phase_fold #(.K(g + 1)) u_fold (
            .x (bus.x_in),
            .q (q_c[g]),
            .o (o_c[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid <= 1'b0;
            for (int i = 0; i < NH; i++) begin
                q_r[i] <= Q0;
                o_r[i] <= '0;
            end
        end else if (adv) begin
            s0_valid <= bus.in_valid;
            if (bus.in_valid) begin
                for (int i = 0; i < NH; i++) begin
                    q_r[i] <= q_c[i];
                    o_r[i] <= o_c[i];
                end
            end
        end
    end

    // Offsets are 0..31 so the LUT's index 32 is never needed.
    assign lut_idx1 = {1'b0, o_r[0]};
    assign lut_idx2 = {1'b0, o_r[1]};
    assign lut_idx3 = {1'b0, o_r[2]};

    assign s_in[0] = lut_sin1;
    assign s_in[1] = lut_sin2;
    assign s_in[2] = lut_sin3;
    assign c_in[0] = lut_cos1;
    assign c_in[1] = lut_cos2;
    assign c_in[2] = lut_cos3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            for (int i = 0; i < NH; i++) begin
                sc_r[i] <= '0;
            end
        end else if (adv) begin
            out_valid_r <= s0_valid;
            for (int i = 0; i < NH; i++) begin
                sc_r[i] <= unfold(q_r[i], s_in[i], c_in[i]);
            end
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.sin_k1    = sc_r[0].sin_v;
    assign bus.sin_k2    = sc_r[1].sin_v;
    assign bus.sin_k3    = sc_r[2].sin_v;
    assign bus.cos_k1    = sc_r[0].cos_v;
    assign bus.cos_k2    = sc_r[1].cos_v;
    assign bus.cos_k3    = sc_r[2].cos_v;

endmodule

// File: tb/tb_trig_expansion_fold.sv
// Self-checking bench for trig_expansion_fold with a real quarter-period LUT
// attached and a trigonometric reference model.
module tb_trig_expansion_fold;
  import trig_fl_pkg::*;

  localparam real PI = 3.14159265358979323846;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  trig_expansion_fold_if bus();

  logic [5:0]  lut_idx1, lut_idx2, lut_idx3;
  logic [15:0] lut_sin1, lut_sin2, lut_sin3;
  logic [15:0] lut_cos1, lut_cos2, lut_cos3;
  logic [15:0] lut_s [64];
  logic [15:0] lut_c [64];

  assign lut_sin1 = lut_s[lut_idx1];
  assign lut_sin2 = lut_s[lut_idx2];
  assign lut_sin3 = lut_s[lut_idx3];
  assign lut_cos1 = lut_c[lut_idx1];
  assign lut_cos2 = lut_c[lut_idx2];
  assign lut_cos3 = lut_c[lut_idx3];

  trig_expansion_fold dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .lut_idx1 (lut_idx1),
    .lut_idx2 (lut_idx2),
    .lut_idx3 (lut_idx3),
    .lut_sin1 (lut_sin1),
    .lut_sin2 (lut_sin2),
    .lut_sin3 (lut_sin3),
    .lut_cos1 (lut_cos1),
    .lut_cos2 (lut_cos2),
    .lut_cos3 (lut_cos3)
  );

  logic signed [16:0] ds [3];
  logic signed [16:0] dc [3];
  assign ds[0] = bus.sin_k1;
  assign ds[1] = bus.sin_k2;
  assign ds[2] = bus.sin_k3;
  assign dc[0] = bus.cos_k1;
  assign dc[1] = bus.cos_k2;
  assign dc[2] = bus.cos_k3;

  // ---------------- bookkeeping ----------------
  int n_chk = 0;
  int n_err = 0;
  int n_in = 0;
  int n_out = 0;
  int n_dropped = 0;
  logic [15:0] exp_q [$];
  bit rand_ready = 1'b0;
  int ready_pct = 80;
  int idle_pct = 20;

  function automatic int rnd(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    else return -$rtoi(-v + 0.5);
  endfunction

  // Quarter-period LUT: entry i is the value at angle i*pi/64.
  initial begin
    for (int i = 0; i < 64; i++) begin
      lut_s[i] = '0;
      lut_c[i] = '0;
    end
    for (int i = 0; i <= 32; i++) begin
      lut_s[i] = 16'(rnd(32768.0 * $sin(i * PI / 64.0)));
      lut_c[i] = 16'(rnd(32768.0 * $cos(i * PI / 64.0)));
    end
  end

  // Full-circle reference: nearest pi/64 step of k*pi*x, then exact sin/cos.
  function automatic int ref_val(input logic [15:0] x, input int k, input bit is_cos);
    int n;
    real a;
    n = ((k * int'($signed(x)) + 256) >>> 9) & 127;
    a = n * PI / 64.0;
    return rnd(32768.0 * (is_cos ? $cos(a) : $sin(a)));
  endfunction

  task automatic chk_eq(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic chk_model(input string nm, input logic [15:0] x, input int k,
                           input bit is_cos, input logic signed [16:0] act);
    int e;
    int a;
    int d;
    real xr;
    real ideal;
    real dr;
    e = ref_val(x, k, is_cos);
    a = int'(act);
    xr = real'(int'($signed(x))) / 32768.0;
    ideal = 32768.0 * (is_cos ? $cos(k * PI * xr) : $sin(k * PI * xr));
    d = (a > e) ? a - e : e - a;
    dr = a - ideal;
    if (dr < 0.0) dr = -dr;
    n_chk++;
    if (d > 1 || dr > 1700.0) begin
      n_err++;
      $display("FAIL %s k=%0d x=%h: got %0d, expected %0d (ideal %0.1f)", nm, k, x, a, e, ideal);
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  bit hold_prev = 1'b0;
  logic [16:0] sv_s [3];
  logic [16:0] sv_c [3];

  initial begin
    logic [15:0] xe;
    bit same;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_prev = 1'b0;
        continue;
      end
      chk_eq("in_ready_rule", int'(bus.in_ready), int'(!bus.out_valid || bus.out_ready));
      if (hold_prev) begin
        same = 1'b1;
        for (int k = 0; k < 3; k++)
          if (ds[k] !== sv_s[k] || dc[k] !== sv_c[k]) same = 1'b0;
        chk_eq("hold_valid", int'(bus.out_valid), 1);
        chk_eq("hold_stable", int'(same), 1);
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(bus.x_in);
        n_in++;
      end
      if (bus.out_valid && bus.out_ready) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_output: got out_valid=1, expected no sample pending");
        end else begin
          xe = exp_q.pop_front();
          n_out++;
          for (int k = 0; k < 3; k++) begin
            chk_model("sin", xe, k + 1, 1'b0, ds[k]);
            chk_model("cos", xe, k + 1, 1'b1, dc[k]);
          end
        end
      end
      hold_prev = bus.out_valid && !bus.out_ready;
      for (int k = 0; k < 3; k++) begin
        sv_s[k] = ds[k];
        sv_c[k] = dc[k];
      end
    end
  end

  // ---------------- downstream ready driver ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) bus.out_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [15:0] x);
    int waited;
    bit acc;
    while ($urandom_range(0, 99) < idle_pct) begin
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.x_in = x;
    waited = 0;
    forever begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      waited++;
      if (waited > 200) begin
        n_chk++;
        n_err++;
        $display("FAIL send_timeout: got no in_ready in 200 cycles, expected acceptance");
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic directed(input logic [15:0] x,
                          input int s1, input int s2, input int s3,
                          input int c1, input int c2, input int c3);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.x_in = x;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk_eq("latency_not_1", int'(bus.out_valid), 0);
    if (x == 16'h8000) begin
      chk_eq("idx1_m1", int'(lut_idx1), 0);
      chk_eq("idx2_m1", int'(lut_idx2), 0);
      chk_eq("idx3_m1", int'(lut_idx3), 0);
    end
    @(posedge clk);
    #1;
    chk_eq("latency_2", int'(bus.out_valid), 1);
    chk_eq("lit_sin_k1", int'(ds[0]), s1);
    chk_eq("lit_sin_k2", int'(ds[1]), s2);
    chk_eq("lit_sin_k3", int'(ds[2]), s3);
    chk_eq("lit_cos_k1", int'(dc[0]), c1);
    chk_eq("lit_cos_k2", int'(dc[1]), c2);
    chk_eq("lit_cos_k3", int'(dc[2]), c3);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_eq({tag, "_out_valid"}, int'(bus.out_valid), 0);
    for (int k = 0; k < 3; k++) begin
      chk_eq({tag, "_sin"}, int'(ds[k]), 0);
      chk_eq({tag, "_cos"}, int'(dc[k]), 0);
    end
    chk_eq({tag, "_idx"}, int'({lut_idx1, lut_idx2, lut_idx3}), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.in_valid = 1'b0;
    bus.x_in = '0;
    bus.out_ready = 1'b0;

    // Pin the reference model with hand-computed values.
    chk_eq("model_sin1_half", ref_val(16'h4000, 1, 1'b0), 32768);
    chk_eq("model_cos2_half", ref_val(16'h4000, 2, 1'b1), -32768);
    chk_eq("model_cos2_m1", ref_val(16'h8000, 2, 1'b1), 32768);
    chk_eq("model_sin3_half", ref_val(16'h4000, 3, 1'b0), -32768);

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    #1;
    chk_eq("in_ready_after_reset", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;

    // Directed literal cases.
    directed(16'h0000, 0, 0, 0, 32768, 32768, 32768);
    directed(16'h4000, 32768, 0, -32768, 0, -32768, 0);
    directed(16'h8000, 0, 0, 0, -32768, 32768, -32768);

    // Backpressure: three samples, output blocked for five cycles.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.x_in = 16'h1234;
    @(posedge clk);
    #1;
    bus.x_in = 16'hC001;
    @(posedge clk);
    #1;
    bus.x_in = 16'h7FFF;
    chk_eq("stall_in_ready_drop", int'(bus.in_ready), 0);
    repeat (5) begin
      @(posedge clk);
      #1;
      chk_eq("stall_in_ready_low", int'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk_eq("stall_drained", exp_q.size(), 0);

    // Reset with two samples in flight.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.x_in = 16'h2222;
    @(posedge clk);
    #1;
    bus.x_in = 16'h3333;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    n_dropped += exp_q.size();
    exp_q.delete();
    @(posedge clk);
    #1;
    chk_reset_outputs("midreset_hold");
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.x_in = 16'h4000;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10 && !bus.out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    chk_eq("post_reset_valid", int'(bus.out_valid), 1);
    chk_eq("post_reset_sin_k1", int'(ds[0]), 32768);
    chk_eq("post_reset_cos_k2", int'(dc[1]), -32768);
    repeat (2) @(posedge clk);
    #1;

    // Randomised sweep across the whole input range under random handshakes.
    rand_ready = 1'b1;
    send(16'h7FFF);
    send(16'h8001);
    send(16'hFFFF);
    send(16'h0001);
    send(16'h8000);
    for (int i = 0; i < 21846; i++) begin
      send(16'(i * 3));
      if ((i % 4000) == 0) ready_pct = $urandom_range(30, 95);
    end
    rand_ready = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1;
    chk_eq("final_queue_empty", exp_q.size(), 0);
    chk_eq("count_in_eq_out", n_in, n_out + n_dropped);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
